vote_collector: RTL and testbench

Ballot-collection stage that sits directly upstream of the four-voter result decoder. It opens a voting session on request, captures one yes/no choice per voter through per-voter cast strobes, and closes the session when all four voters have cast or a timeout expires. The closed 4-bit ballot, with any missing vote counted as "no", is then presented to the decoder's 4-bit vote input under a valid/ready handshake.

---
 rtl/vote_pkg.sv | 17 +
 rtl/vote_timeout_counter.sv | 30 +++
 rtl/vote_collector.sv | 92 +++++++++
 tb/tb_vote_collector.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the vote collector and its downstream result decoder.
package vote_pkg;

    localparam int unsigned N_VOTERS = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StPresent
    } vote_state_e;

    // Result encodings used by the four-voter decoder fed from the ballot.
    localparam logic [2:0] AGAINST = 3'b001;
    localparam logic [2:0] TIE     = 3'b010;
    localparam logic [2:0] FOR     = 3'b100;

endpackage

// File: rtl/vote_timeout_counter.sv
// Session timer: counts enabled cycles from a clear and flags the final cycle of the session window.
module vote_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned WIDTH          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WIDTH-1:0] count_q;

    assign done = (count_q == LAST);

    // Saturates at LAST so the timer can never wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !done) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vote_collector.sv
// Collects one yes/no vote per voter per session and presents the closed ballot under valid/ready.
// Define VOTE_REVOTE_EN to let a voter overwrite an earlier cast while the session is open.
module vote_collector
    import vote_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_VOTERS-1:0] cast,
    input  logic [N_VOTERS-1:0] choice,
    output logic [N_VOTERS-1:0] ballot,
    output logic [N_VOTERS-1:0] cast_mask,
    output logic                ballot_valid,
    input  logic                ballot_ready,
    output logic                busy,
    output logic                timed_out
);

    localparam logic [N_VOTERS-1:0] ALL_CAST = '1;

    vote_state_e         state_q;
    logic                timer_done;
    logic [N_VOTERS-1:0] write_en;
    logic [N_VOTERS-1:0] next_mask;
    logic [N_VOTERS-1:0] next_ballot;

    // Timer is held clear for the whole idle period, so it starts at zero on session open.
    vote_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == StIdle),
        .enable(state_q == StCollect),
        .done  (timer_done)
    );

    always_comb begin
`ifdef VOTE_REVOTE_EN
        write_en = cast;
`else
        write_en = cast & ~cast_mask;
`endif
        next_mask   = cast_mask | cast;
        next_ballot = (ballot & ~write_en) | (choice & write_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ballot       <= '0;
            cast_mask    <= '0;
            ballot_valid <= 1'b0;
            busy         <= 1'b0;
            timed_out    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StCollect;
                        ballot    <= '0;
                        cast_mask <= '0;
                        timed_out <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                StCollect: begin
                    ballot    <= next_ballot;
                    cast_mask <= next_mask;
                    // Completion wins over a coincident timeout.
                    if (next_mask == ALL_CAST || timer_done) begin
                        state_q      <= StPresent;
                        ballot_valid <= 1'b1;
                        timed_out    <= (next_mask != ALL_CAST);
                    end
                end
                StPresent: begin
                    if (ballot_ready) begin
                        state_q      <= StIdle;
                        ballot_valid <= 1'b0;
                        busy         <= 1'b0;
                        timed_out    <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vote_collector.sv
// Self-checking bench for vote_collector: directed scenarios plus random traffic against a session model.
module tb_vote_collector;

    localparam int unsigned T = 8;
`ifdef VOTE_REVOTE_EN
    localparam bit REVOTE = 1'b1;
`else
    localparam bit REVOTE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] cast;
    logic [3:0] choice;
    logic [3:0] ballot;
    logic [3:0] cast_mask;
    logic       ballot_valid;
    logic       ballot_ready;
    logic       busy;
    logic       timed_out;

    int passed = 0;
    int total  = 0;

    // Session model: phase 0 = idle, 1 = collecting, 2 = presenting.
    int         m_phase;
    int         m_elapsed;
    logic [3:0] m_ballot;
    logic [3:0] m_mask;
    logic       m_to;

    always #5 clk = ~clk;

    vote_collector #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cast        (cast),
        .choice      (choice),
        .ballot      (ballot),
        .cast_mask   (cast_mask),
        .ballot_valid(ballot_valid),
        .ballot_ready(ballot_ready),
        .busy        (busy),
        .timed_out   (timed_out)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b, expected %b", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, "/ballot"}, ballot, m_ballot);
        check({tag, "/cast_mask"}, cast_mask, m_mask);
        check({tag, "/valid"}, {3'b000, ballot_valid}, {3'b000, m_phase == 2});
        check({tag, "/busy"}, {3'b000, busy}, {3'b000, m_phase != 0});
        check({tag, "/timed_out"}, {3'b000, timed_out}, {3'b000, m_to});
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_ballot  = 4'b0000;
        m_mask    = 4'b0000;
        m_to      = 1'b0;
    endtask

    // Applies one clock edge's worth of the session rules to the model.
    task automatic model_step();
        case (m_phase)
            0: if (start) begin
                m_phase   = 1;
                m_elapsed = 0;
                m_ballot  = 4'b0000;
                m_mask    = 4'b0000;
                m_to      = 1'b0;
            end
            1: begin
                for (int i = 0; i < 4; i++) begin
                    if (cast[i] && (!m_mask[i] || REVOTE)) m_ballot[i] = choice[i];
                end
                m_mask = m_mask | cast;
                m_elapsed++;
                if (m_mask == 4'b1111) begin
                    m_phase = 2;
                    m_to    = 1'b0;
                end else if (m_elapsed == int'(T)) begin
                    m_phase = 2;
                    m_to    = 1'b1;
                end
            end
            default: if (ballot_ready) begin
                m_phase = 0;
                m_to    = 1'b0;
            end
        endcase
    endtask

    task automatic step(input logic st, input logic [3:0] c, input logic [3:0] ch,
                        input logic rdy, input string tag);
        start        = st;
        cast         = c;
        choice       = ch;
        ballot_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    logic [3:0] held;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cast = 4'b0000;
        choice = 4'b0000;
        ballot_ready = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // All four voters in one cycle.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "open_a");
        step(1'b0, 4'b1111, 4'b1011, 1'b0, "cast_all");
        check("all_ballot", ballot, 4'b1011);
        check("all_valid", {3'b000, ballot_valid}, 4'b0001);
        step(1'b0, 4'b0000, 4'b0000, 1'b1, "accept_a");

        // Voters cast on successive cycles.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "open_b");
        step(1'b0, 4'b0001, 4'b0001, 1'b0, "seq0");
        check("seq_mask0", cast_mask, 4'b0001);
        step(1'b0, 4'b0010, 4'b0000, 1'b0, "seq1");
        step(1'b0, 4'b0100, 4'b0100, 1'b0, "seq2");
        step(1'b0, 4'b1000, 4'b0000, 1'b0, "seq3");
        check("seq_ballot", ballot, 4'b0101);
        step(1'b0, 4'b0000, 4'b0000, 1'b1, "accept_b");

        // Timeout with only voter 2 voting yes.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "open_c");
        step(1'b0, 4'b0100, 4'b0100, 1'b0, "to_cast");
        repeat (6) step(1'b0, 4'b0000, 4'b0000, 1'b0, "to_wait");
        check("to_not_yet", {3'b000, ballot_valid}, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000, 1'b0, "to_close");
        check("to_valid", {3'b000, ballot_valid}, 4'b0001);
        check("to_flag", {3'b000, timed_out}, 4'b0001);
        check("to_ballot", ballot, 4'b0100);
        step(1'b0, 4'b0000, 4'b0000, 1'b1, "accept_c");

        // Voter 1 changes mind; then hold PRESENT while poking inputs.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "open_d");
        step(1'b0, 4'b0010, 4'b0010, 1'b0, "revote_yes");
        step(1'b0, 4'b0010, 4'b0000, 1'b0, "revote_no");
        check("revote_bit", {3'b000, ballot[1]}, {3'b000, !REVOTE});
        step(1'b0, 4'b1101, 4'b0000, 1'b0, "revote_fill");
        held = ballot;
        for (int i = 0; i < 5; i++) begin
            step(i[0], 4'($urandom), 4'($urandom), 1'b0, "hold");
            check("hold_stable", ballot, held);
        end
        step(1'b0, 4'b0000, 4'b0000, 1'b1, "accept_d");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, "idle_gap");

        // Asynchronous reset mid-session.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "open_e");
        step(1'b0, 4'b0011, 4'b0011, 1'b0, "pre_reset");
        check("pre_reset_mask", cast_mask, 4'b0011);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "open_f");
        step(1'b0, 4'b1000, 4'b1000, 1'b0, "clean_cast");

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(3) == 0), 4'($urandom & $urandom & $urandom),
                 4'($urandom), $urandom_range(1) == 1, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
